// File: rtl/sbox_word_feeder_if.sv
// Word-in / byte-out handshake bundle between an upstream column source and the
// AES S-box feeder. The feeder is the word-bus slave and drives the byte stream.
interface sbox_word_feeder_if #(
    parameter int NUM_BYTES = 4,
    parameter int IDX_W     = 2
);
    logic                   word_valid;
    logic                   word_ready;
    logic [8*NUM_BYTES-1:0] word_data;
    logic                   word_encrypt;
    logic                   byte_valid;
    logic                   byte_ready;
    logic [7:0]             G;
    logic                   encrypt;
    logic [IDX_W-1:0]       byte_idx;
    logic                   byte_last;

    // Upstream word source plus downstream byte sink.
    modport master (
        output word_valid, word_data, word_encrypt, byte_ready,
        input  word_ready, byte_valid, G, encrypt, byte_idx, byte_last
    );

    // The feeder itself.
    modport slave (
        input  word_valid, word_data, word_encrypt, byte_ready,
        output word_ready, byte_valid, G, encrypt, byte_idx, byte_last
    );
endinterface

// File: rtl/sbox_word_feeder.sv
// Serialises one state column per handshake into bytes for the shared AES
// S-box, holding operand and direction stable across downstream stalls.
module sbox_word_feeder #(
    parameter int NUM_BYTES = 4,
    parameter int IDX_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    sbox_word_feeder_if.slave    bus
);
    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    state_t                 state, state_d;
    logic [8*NUM_BYTES-1:0] word_q;
    logic                   enc_q;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   load;
    logic                   last;
    logic                   word_acc;
    logic                   byte_xfer;
    logic [7:0]             g_mux;

    assign last      = (state == SEND) && (idx_q == LAST_IDX);
    assign word_acc  = bus.word_valid && bus.word_ready;
    assign byte_xfer = (state == SEND) && bus.byte_ready;

    // Ready may follow byte_ready combinationally so the next word lands in the
    // same edge the last byte leaves: no bubble between words.
    assign bus.word_ready = !rst && ((state == IDLE) || (last && bus.byte_ready));

    assign bus.byte_valid = (state == SEND);
    assign bus.byte_last  = last;
    assign bus.encrypt    = enc_q;
    assign bus.byte_idx   = idx_q;
    assign bus.G          = g_mux;

    // Byte select is driven purely from registers, never from word_data.
    always_comb begin
        g_mux = 8'h00;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                g_mux = word_q[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx_q;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (word_acc) begin
                    state_d = SEND;
                    idx_d   = '0;
                    load    = 1'b1;
                end
            end
            SEND: begin
                if (byte_xfer) begin
                    if (!last) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else if (word_acc) begin
                        state_d = SEND;
                        idx_d   = '0;
                        load    = 1'b1;
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx_q  <= '0;
            word_q <= '0;
            enc_q  <= 1'b0;
        end else begin
            state <= state_d;
            idx_q <= idx_d;
            if (load) begin
                word_q <= bus.word_data;
                enc_q  <= bus.word_encrypt;
            end
        end
    end
endmodule

// File: tb/tb_sbox_word_feeder.sv
// Directed bench for sbox_word_feeder: a byte-queue reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_sbox_word_feeder;
    localparam int NB = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sbox_word_feeder_if #(.NUM_BYTES(NB), .IDX_W(IW)) bus ();

    sbox_word_feeder #(.NUM_BYTES(NB), .IDX_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [7:0]    g;
        logic          enc;
        logic [IW-1:0] idx;
        logic          last;
    } exp_t;

    typedef struct {
        logic [7:0] g;
        logic       enc;
        logic       wr;
        int         cyc;
    } log_t;

    exp_t model_q[$];
    log_t log_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a word accept queues its bytes in order; the front of the
    // queue is what must be on the byte bus.
    always @(negedge clk) begin
        logic exp_wr, xfer, acc;
        exp_t e;
        if (rst) begin
            model_q.delete();
        end else begin
            exp_wr = (model_q.size() == 0) || (model_q.size() == 1 && bus.byte_ready);
            chk("m_word_ready", bus.word_ready, exp_wr);
            chk("m_byte_valid", bus.byte_valid, model_q.size() != 0);
            if (model_q.size() != 0) begin
                chk("m_G", bus.G, model_q[0].g);
                chk("m_encrypt", bus.encrypt, model_q[0].enc);
                chk("m_byte_idx", bus.byte_idx, model_q[0].idx);
                chk("m_byte_last", bus.byte_last, model_q[0].last);
            end
            xfer = (model_q.size() != 0) && bus.byte_ready;
            acc  = bus.word_valid && exp_wr;
            if (xfer) begin
                log_q.push_back('{g: bus.G, enc: bus.encrypt, wr: bus.word_ready, cyc: cyc});
                void'(model_q.pop_front());
            end
            if (acc) begin
                for (int k = 0; k < NB; k++) begin
                    e.g    = bus.word_data[8*k +: 8];
                    e.enc  = bus.word_encrypt;
                    e.idx  = IW'(k);
                    e.last = (k == NB - 1);
                    model_q.push_back(e);
                end
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input string nm);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.word_ready && bus.word_valid;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (bus.byte_valid && n < 100) begin
            tick();
            n++;
        end
        if (bus.byte_valid) chk({nm, "_drain_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic chk_log(input string nm, input logic [8*NB*2-1:0] bytes, input int nbytes,
                           input logic [7:0] encs);
        chk({nm, "_log_count"}, log_q.size(), nbytes);
        for (int i = 0; i < nbytes && i < log_q.size(); i++) begin
            chk({nm, "_log_G"}, log_q[i].g, bytes[8*i +: 8]);
            chk({nm, "_log_enc"}, log_q[i].enc, encs[i]);
        end
    endtask

    initial begin
        logic [8*NB*2-1:0] bytes;
        bus.word_valid   = 1'b0;
        bus.word_data    = '0;
        bus.word_encrypt = 1'b0;
        bus.byte_ready   = 1'b0;

        // Reset state
        #1;
        chk("rst_byte_valid", bus.byte_valid, 0);
        chk("rst_G", bus.G, 0);
        chk("rst_encrypt", bus.encrypt, 0);
        chk("rst_byte_idx", bus.byte_idx, 0);
        chk("rst_byte_last", bus.byte_last, 0);
        chk("rst_word_ready", bus.word_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_word_ready", bus.word_ready, 1);

        // Single word
        bus.byte_ready   = 1'b1;
        bus.word_valid   = 1'b1;
        bus.word_data    = 32'h33221100;
        bus.word_encrypt = 1'b1;
        wait_accept("single");
        bus.word_valid = 1'b0;
        for (int i = 0; i < NB; i++) begin
            chk("single_G", bus.G, 32'h11 * i);
            chk("single_idx", bus.byte_idx, i);
            chk("single_last", bus.byte_last, i == NB - 1);
            chk("single_enc", bus.encrypt, 1);
            chk("single_word_ready", bus.word_ready, i == NB - 1);
            tick();
        end
        chk("single_idle_valid", bus.byte_valid, 0);

        // Back-to-back words
        log_q.delete();
        bus.word_valid   = 1'b1;
        bus.word_data    = 32'hDDCCBBAA;
        bus.word_encrypt = 1'b1;
        wait_accept("b2b0");
        bus.word_data    = 32'h44332211;
        bus.word_encrypt = 1'b0;
        wait_accept("b2b1");
        bus.word_valid = 1'b0;
        drain("b2b");
        bytes = 64'h44332211DDCCBBAA;
        chk_log("b2b", bytes, 8, 8'b00001111);
        if (log_q.size() == 8) begin
            chk("b2b_contiguous", log_q[7].cyc - log_q[0].cyc, 7);
            chk("b2b_ready_at_DD", log_q[3].wr, 1);
        end

        // Downstream stall on BB
        log_q.delete();
        bus.word_valid   = 1'b1;
        bus.word_data    = 32'hDDCCBBAA;
        bus.word_encrypt = 1'b0;
        wait_accept("stall");
        bus.word_valid = 1'b0;
        chk("stall_G0", bus.G, 8'hAA);
        tick();
        chk("stall_G1", bus.G, 8'hBB);
        bus.byte_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("stall_hold_G", bus.G, 8'hBB);
            chk("stall_hold_idx", bus.byte_idx, 1);
            chk("stall_hold_enc", bus.encrypt, 0);
            chk("stall_hold_valid", bus.byte_valid, 1);
        end
        bus.byte_ready = 1'b1;
        tick();
        chk("stall_resume_G", bus.G, 8'hCC);
        drain("stall");
        bytes = {32'h0, 32'hDDCCBBAA};
        chk_log("stall", bytes, 4, 8'b00000000);

        // Last-byte stall with a pending word
        log_q.delete();
        bus.word_valid   = 1'b1;
        bus.word_data    = 32'h87654321;
        bus.word_encrypt = 1'b1;
        wait_accept("lstall0");
        bus.word_data    = 32'h0F0E0D0C;
        bus.word_encrypt = 1'b0;
        repeat (3) tick();
        chk("lstall_idx3", bus.byte_idx, 3);
        bus.byte_ready = 1'b0;
        #1;
        chk("lstall_ready_low", bus.word_ready, 0);
        repeat (3) begin
            tick();
            chk("lstall_hold_ready", bus.word_ready, 0);
            chk("lstall_hold_G", bus.G, 8'h87);
        end
        bus.byte_ready = 1'b1;
        #1;
        chk("lstall_ready_rise", bus.word_ready, 1);
        @(posedge clk);
        #1;
        chk("lstall_next_G", bus.G, 8'h0C);
        chk("lstall_next_idx", bus.byte_idx, 0);
        chk("lstall_next_enc", bus.encrypt, 0);
        bus.word_valid = 1'b0;
        drain("lstall");
        bytes = 64'h0F0E0D0C87654321;
        chk_log("lstall", bytes, 8, 8'b00001111);

        // Asynchronous reset mid-word
        bus.word_valid   = 1'b1;
        bus.word_data    = 32'h78563412;
        bus.word_encrypt = 1'b1;
        wait_accept("mrst");
        bus.word_valid = 1'b0;
        repeat (2) tick();
        chk("mrst_idx2", bus.byte_idx, 2);
        chk("mrst_G2", bus.G, 8'h56);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_async_valid", bus.byte_valid, 0);
        chk("mrst_async_G", bus.G, 0);
        chk("mrst_async_ready", bus.word_ready, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("mrst_after_ready", bus.word_ready, 1);
        chk("mrst_after_valid", bus.byte_valid, 0);
        bus.word_valid   = 1'b1;
        bus.word_data    = 32'hCAFEBABE;
        bus.word_encrypt = 1'b0;
        wait_accept("mrst_fresh");
        bus.word_valid = 1'b0;
        chk("mrst_fresh_idx", bus.byte_idx, 0);
        chk("mrst_fresh_G", bus.G, 8'hBE);
        drain("mrst_fresh");

        // Inputs toggled while not ready
        log_q.delete();
        bus.word_valid   = 1'b1;
        bus.word_data    = 32'h0BADF00D;
        bus.word_encrypt = 1'b1;
        wait_accept("ign");
        bus.word_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.word_data    = $urandom;
            bus.word_encrypt = 1'($urandom_range(0, 1));
            bus.byte_ready   = 1'($urandom_range(0, 1));
            tick();
        end
        bus.byte_ready = 1'b1;
        drain("ign");
        bytes = {32'h0, 32'h0BADF00D};
        chk_log("ign", bytes, 4, 8'b00001111);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sbox_word_feeder.md
# sbox_word_feeder

Upstream feeder for the combined AES S-box/inverse S-box datapath. It accepts one 32-bit state column per valid/ready handshake, together with a direction flag. It then presents the four bytes one per handshake to the single shared S-box as the 8-bit input `G` plus the `encrypt` select. It holds `G` and `encrypt` stable across downstream stalls, so the S-box's input transform sees a clean operand. It supports back-to-back words with no bubble.

## Interface
- `NUM_BYTES`, default 4: bytes per input word; must be a power of two, ≥2.
- `IDX_W`, default 2: width of the byte index, equal to log2(`NUM_BYTES`).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `word_valid`  in  1  upstream word valid.
- `word_ready`  out  1  feeder can accept a word this cycle.
- `word_data`  in  8*`NUM_BYTES`  word to serialize; byte k is `word_data[8k+7:8k]`.
- `word_encrypt`  in  1  1 selects forward S-box, 0 selects inverse; sampled with the word.
- `byte_valid`  out  1  `G`/`encrypt`/`byte_idx`/`byte_last` are valid.
- `byte_ready`  in  1  S-box stage accepts the byte.
- `G`  out  8  byte presented to the S-box.
- `encrypt`  out  1  direction for the current word.
- `byte_idx`  out  `IDX_W`  index of the byte on `G`.
- `byte_last`  out  1  high when `byte_idx` equals `NUM_BYTES`-1.

## Operation
- State machine with two states.
  - IDLE: no word is held.
  - SEND: a word is held.
- Registers:
  - `word_q` (8*`NUM_BYTES` bits)
  - `enc_q`
  - `idx_q` (`IDX_W` bits)
  - `state`
- Handshake definitions:
  - Word accept occurs on a cycle where `word_valid` and `word_ready` are both high.
  - Byte transfer occurs on a cycle where `byte_valid` and `byte_ready` are both high.
- `word_ready` = (`state`==IDLE) OR (`state`==SEND AND `byte_last` AND `byte_ready`).
  - This is a combinational path from `byte_ready`.
  - `word_ready` is forced to 0 while `rst` is high.
- Word accept:
  - Load `word_q` from `word_data`.
  - Load `enc_q` from `word_encrypt`.
  - Set `idx_q` to 0.
  - Move `state` to SEND.
  - This applies from IDLE and also when the last byte transfers in the same cycle (back-to-back case).
- In SEND:
  - `byte_valid` is 1.
  - `G` = `word_q[8*idx_q +: 8]`.
  - `encrypt` = `enc_q`.
  - `byte_idx` = `idx_q`.
- Byte transfer, not the last byte: `idx_q` increments by 1.
- Byte transfer, last byte, no simultaneous word accept:
  - `state` goes to IDLE.
  - `idx_q` goes to 0.
  - `word_q` and `enc_q` keep their values.
- In IDLE:
  - `byte_valid` is 0 and `byte_last` is 0.
  - `G`, `encrypt` and `byte_idx` reflect the held registers and are don't-care downstream.
- Stall: while `byte_valid` is high and `byte_ready` is low, all of `G`, `encrypt`, `byte_idx` and `byte_last` hold exactly.
- `enc_q` never changes mid-word; a new `word_encrypt` takes effect only at a word accept.
- `byte_valid` never drops once asserted until the last byte of the word has transferred.
- `word_data` and `word_encrypt` are ignored on any cycle where `word_ready` is 0.

## Timing
- Reset values, all forced asynchronously while `rst` is high:
  - `state` = IDLE and `idx_q` = 0.
  - `word_q` = 0 and `enc_q` = 0.
  - `byte_valid` = 0, `G` = 8'h00, `encrypt` = 0, `byte_idx` = 0, `byte_last` = 0.
  - `word_ready` = 0.
- `word_ready` rises in the first cycle after `rst` deasserts.
- Latency: a word accepted at edge N puts byte 0 on `G` with `byte_valid`=1 immediately after edge N. It is transferable in cycle N+1.
- Throughput: one byte per cycle with `byte_ready` held high. This gives one word per `NUM_BYTES` cycles, with no idle cycle between words when `word_valid` is continuously high.
- Index wrap: `idx_q` never exceeds `NUM_BYTES`-1; after the last byte it returns to 0.
- Reset mid-word: the word is discarded immediately and `byte_valid` falls asynchronously. After release the block is in IDLE; the partial word is never resumed.
- Outputs `G`, `encrypt`, `byte_idx` and `byte_last` are driven from registers through the byte mux only. There is no combinational path from `word_data` to `G`.

## Test plan
- Reset then single word: `rst` pulse, then `word_data`=32'h33221100 with `word_encrypt`=1 and `byte_ready`=1. Required: `G` = 00, 11, 22, 33 on four consecutive cycles, `byte_idx` = 0..3, `byte_last` only with 33, `encrypt`=1 throughout, and `word_ready` low during bytes 0–2.
- Back-to-back words: words 32'hDDCCBBAA (`encrypt`=1) and 32'h44332211 (`encrypt`=0) offered continuously. Required: eight contiguous byte transfers AA BB CC DD 11 22 33 44, with `encrypt` switching 1→0 exactly at byte 11, and `word_ready`=1 in the cycle DD transfers.
- Downstream stall: drop `byte_ready` for 3 cycles while `G`=BB, `byte_idx`=1. Required: `G`, `byte_idx`, `encrypt` and `byte_valid` are constant for all 3 cycles, then the stream resumes with CC; no byte is lost or duplicated.
- Last-byte stall: hold `byte_ready`=0 at `byte_idx`=3 with `word_valid`=1 pending. Required: `word_ready`=0 until `byte_ready` rises, and the next word is accepted on exactly that cycle.
- Reset mid-word: assert `rst` asynchronously while `byte_idx`=2. Required: `byte_valid`, `G` and `word_ready` go to 0 without waiting for a clock edge. After release, `word_ready`=1, and a fresh word starts at `byte_idx`=0.
- Input ignored when not ready: toggle `word_data` and `word_encrypt` randomly during SEND. Required: the emitted bytes and `encrypt` match only the word captured at accept.
